// File: rtl/frogger_pkg.sv
// Shared types and constants for the frogger sprite blocks.
// Optional build macro used by frog_ctrl: FROG_FACING_EN.
package frogger_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  localparam logic [5:0] COL_BLACK = 6'b000000;
  localparam logic [5:0] COL_WHITE = 6'b111111;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, HOP, DYING, GAMEOVER} frog_state_t;

  // One-deep pending hop request
  typedef struct packed {
    logic valid;
    dir_t dir;
  } hop_req_t;

  // Signed column displacement for a move of 'step' pixels in direction d
  function automatic logic signed [10:0] step_dx(input dir_t d, input int step);
    logic signed [10:0] s;
    s = 11'(step);
    case (d)
      RIGHT:   return s;
      LEFT:    return -s;
      default: return 11'sd0;
    endcase
  endfunction

  // Signed row displacement (screen rows grow downward)
  function automatic logic signed [10:0] step_dy(input dir_t d, input int step);
    logic signed [10:0] s;
    s = 11'(step);
    case (d)
      DOWN:    return s;
      UP:      return -s;
      default: return 11'sd0;
    endcase
  endfunction

endpackage

// File: rtl/frog_render.sv
// Registered sprite coverage/colour for one square sprite; latency 1 clk.
// Optional eye stripe along the facing edge when eye_en is high.
module frog_render
  import frogger_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int EYE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] colPos,
  input  logic [9:0] rowPos,
  input  logic [9:0] spr_x,
  input  logic [9:0] spr_y,
  input  logic [5:0] body_color,
  input  logic       eye_en,
  input  dir_t       facing,
  output logic [5:0] color,
  output logic       pix_valid
);

  logic [10:0] dx, dy;
  logic        covered, eye;
  logic [5:0]  px_color;

  // Offsets into the sprite; only meaningful when scan >= sprite origin
  assign dx = {1'b0, colPos} - {1'b0, spr_x};
  assign dy = {1'b0, rowPos} - {1'b0, spr_y};
  assign covered = (colPos >= spr_x) && (dx < 11'(SIZE)) &&
                   (rowPos >= spr_y) && (dy < 11'(SIZE));

  // Eye stripe selection along the edge the sprite faces
  always_comb begin
    eye = 1'b0;
    case (facing)
      UP:    eye = dy <  11'(EYE_DEPTH);
      DOWN:  eye = dy >= 11'(SIZE - EYE_DEPTH);
      LEFT:  eye = dx <  11'(EYE_DEPTH);
      RIGHT: eye = dx >= 11'(SIZE - EYE_DEPTH);
      default: eye = 1'b0;
    endcase
    px_color = (eye_en && eye) ? COL_WHITE : body_color;
  end

  // Register colour and coverage for the pixel mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color     <= COL_BLACK;
      pix_valid <= 1'b0;
    end else begin
      color     <= covered ? px_color : COL_BLACK;
      pix_valid <= covered && (px_color != COL_BLACK);
    end
  end

endmodule

// File: rtl/frog_ctrl.sv
// Frog sprite engine: position, grid hops, clamping, death/respawn, lives.
// Build macro FROG_FACING_EN adds a facing register and eye stripe.
module frog_ctrl
  import frogger_pkg::*;
#(
  parameter int          SCREEN_W     = SCREEN_W_DEF,
  parameter int          SCREEN_H     = SCREEN_H_DEF,
  parameter int          FROG_SIZE    = 32,
  parameter int          HOP_STEP     = 32,
  parameter int          HOP_FRAMES   = 4,
  parameter int          START_X      = 304,
  parameter int          START_Y      = 448,
  parameter int          LIVES        = 3,
  parameter int          DEATH_FRAMES = 30,
  parameter logic [5:0]  FROG_COLOR   = 6'b110000,
  parameter logic [5:0]  DEATH_COLOR  = 6'b111100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  input  logic [9:0] colPos,
  input  logic [9:0] rowPos,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic [5:0] color,
  output logic       pix_valid,
  output logic [2:0] lives,
  output logic       goal,
  output logic       game_over
);

  localparam int STEP = HOP_STEP / HOP_FRAMES;
  localparam int HCW  = (HOP_FRAMES < 2) ? 1 : $clog2(HOP_FRAMES);
  // At least 3 bits so bit 2 selects the 4-frame flash block
  localparam int DCW  = ($clog2(DEATH_FRAMES + 1) < 3) ? 3 : $clog2(DEATH_FRAMES + 1);
  localparam logic signed [10:0] MAX_X = 11'(SCREEN_W - FROG_SIZE);
  localparam logic signed [10:0] MAX_Y = 11'(SCREEN_H - FROG_SIZE);
  localparam logic signed [10:0] SX    = 11'(START_X);
  localparam logic signed [10:0] SY    = 11'(START_Y);

  frog_state_t state, state_nxt;
  hop_req_t    req;
  dir_t        edge_dir, hop_dir;
  logic [3:0]  btn, btn_q, rise;
  logic signed [10:0] pos_x, pos_y, tgt_x, tgt_y, cand_x, cand_y;
  logic [HCW-1:0] hop_cnt;
  logic [DCW-1:0] death_cnt;
  logic        in_range, accept, drop, arrive, expire;
  logic [5:0]  body_color;
  logic        eye_en;
  dir_t        facing;

  assign btn    = {btn_right, btn_left, btn_down, btn_up};
  assign rise   = btn & ~btn_q;
  assign frog_x = pos_x[9:0];
  assign frog_y = pos_y[9:0];

  // Same-cycle edges resolve up > down > left > right
  always_comb begin
    edge_dir = RIGHT;
    if (rise[0])      edge_dir = UP;
    else if (rise[1]) edge_dir = DOWN;
    else if (rise[2]) edge_dir = LEFT;
  end

  // Candidate landing spot for the pending request, with range check
  always_comb begin
    cand_x   = pos_x + step_dx(req.dir, HOP_STEP);
    cand_y   = pos_y + step_dy(req.dir, HOP_STEP);
    in_range = (cand_x >= 11'sd0) && (cand_x <= MAX_X) &&
               (cand_y >= 11'sd0) && (cand_y <= MAX_Y);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; every transition waits for frame_tick
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drop      = 1'b0;
    arrive    = 1'b0;
    expire    = 1'b0;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (hit) state_nxt = DYING;
          else if (req.valid) begin
            if (in_range) begin
              accept    = 1'b1;
              state_nxt = HOP;
            end else begin
              drop = 1'b1;
            end
          end
        end
        HOP: begin
          if (hit) state_nxt = DYING;
          else if (hop_cnt == HCW'(HOP_FRAMES - 1)) begin
            arrive    = 1'b1;
            state_nxt = IDLE;
          end
        end
        DYING: begin
          if (death_cnt == DCW'(DEATH_FRAMES - 1)) begin
            expire    = 1'b1;
            state_nxt = (lives == 3'd1) ? GAMEOVER : IDLE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Output decode: body colour, flashing on alternate 4-frame blocks while dying
  always_comb begin
    body_color = FROG_COLOR;
    if (state == DYING) body_color = death_cnt[2] ? COL_BLACK : DEATH_COLOR;
  end

  // Button edge history and one-deep request buffer (newest edge wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 4'b0;
      req   <= '{valid: 1'b0, dir: UP};
    end else begin
      btn_q <= btn;
      if (|rise)                           req <= '{valid: 1'b1, dir: edge_dir};
      else if (accept || drop || expire)   req.valid <= 1'b0;
    end
  end

  // Position, hop/death counters, lives and goal/game-over flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x     <= SX;
      pos_y     <= SY;
      tgt_x     <= SX;
      tgt_y     <= SY;
      hop_dir   <= UP;
      hop_cnt   <= '0;
      death_cnt <= '0;
      lives     <= 3'(LIVES);
      goal      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      goal <= 1'b0;
      if (frame_tick) begin
        case (state)
          IDLE: begin
            hop_cnt   <= '0;
            death_cnt <= '0;
            if (accept) begin
              tgt_x   <= cand_x;
              tgt_y   <= cand_y;
              hop_dir <= req.dir;
            end
          end
          HOP: begin
            if (hit) begin
              death_cnt <= '0;
            end else if (arrive) begin
              hop_cnt <= '0;
              if (tgt_y == 11'sd0) begin
                goal  <= 1'b1;
                pos_x <= SX;
                pos_y <= SY;
              end else begin
                pos_x <= tgt_x;
                pos_y <= tgt_y;
              end
            end else begin
              pos_x   <= pos_x + step_dx(hop_dir, STEP);
              pos_y   <= pos_y + step_dy(hop_dir, STEP);
              hop_cnt <= hop_cnt + HCW'(1);
            end
          end
          DYING: begin
            if (expire) begin
              death_cnt <= '0;
              lives     <= lives - 3'd1;
              if (lives == 3'd1) begin
                game_over <= 1'b1;
              end else begin
                pos_x <= SX;
                pos_y <= SY;
              end
            end else begin
              death_cnt <= death_cnt + DCW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FROG_FACING_EN
  // Facing follows each accepted hop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      facing <= UP;
    else if (accept) facing <= req.dir;
  end
  assign eye_en = (state != DYING);
`else
  assign facing = UP;
  assign eye_en = 1'b0;
`endif

  frog_render #(
    .SIZE      (FROG_SIZE),
    .EYE_DEPTH (4)
  ) u_render (
    .clk        (clk),
    .rst_n      (rst_n),
    .colPos     (colPos),
    .rowPos     (rowPos),
    .spr_x      (frog_x),
    .spr_y      (frog_y),
    .body_color (body_color),
    .eye_en     (eye_en),
    .facing     (facing),
    .color      (color),
    .pix_valid  (pix_valid)
  );

endmodule

// File: tb/tb_frog_ctrl.sv
// Directed bench for frog_ctrl (default parameters).
module tb_frog_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] colPos = '0, rowPos = '0;
  logic [9:0] frog_x, frog_y;
  logic [5:0] color;
  logic       pix_valid;
  logic [2:0] lives;
  logic       goal, game_over;
  logic       goal_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frog_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .hit        (hit),
    .colPos     (colPos),
    .rowPos     (rowPos),
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .color      (color),
    .pix_valid  (pix_valid),
    .lives      (lives),
    .goal       (goal),
    .game_over  (game_over)
  );

  task automatic tick(input logic h);
    @(negedge clk);
    frame_tick = 1'b1;
    hit        = h;
    @(negedge clk);
    frame_tick = 1'b0;
    hit        = 1'b0;
    goal_seen  = goal;
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    @(negedge clk);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  task automatic do_hop(input logic u, input logic d, input logic l, input logic r);
    press(u, d, l, r);
    for (int i = 0; i < 5; i++) tick(1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #22;
    checks++; if (frog_x !== 10'd304) begin errors++; $display("FAIL reset_x got %0d exp 304", frog_x); end
    checks++; if (frog_y !== 10'd448) begin errors++; $display("FAIL reset_y got %0d exp 448", frog_y); end
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", lives); end
    checks++; if (color !== 6'd0 || pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix got %b/%b exp 000000/0", color, pix_valid); end
    checks++; if (goal !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL reset_flags got %b/%b exp 0/0", goal, game_over); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pixel();
    logic [9:0] cols [4];
    logic [9:0] rows [4];
    logic [5:0] exp_c [4];
    cols = '{10'd304, 10'd336, 10'd335, 10'd304};
    rows = '{10'd448, 10'd448, 10'd479, 10'd447};
`ifdef FROG_FACING_EN
    exp_c = '{6'b111111, 6'b000000, 6'b110000, 6'b000000};
`else
    exp_c = '{6'b110000, 6'b000000, 6'b110000, 6'b000000};
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      colPos = cols[i];
      rowPos = rows[i];
      @(negedge clk);
      checks++;
      if (color !== exp_c[i] || pix_valid !== (exp_c[i] != 6'd0)) begin
        errors++;
        $display("FAIL pixel_%0d got %b/%b exp %b/%b", i, color, pix_valid, exp_c[i], exp_c[i] != 6'd0);
      end
    end
  endtask

  task automatic test_hop_up();
    press(1, 0, 0, 0);
    tick(1'b0);
    checks++; if (frog_y !== 10'd448) begin errors++; $display("FAIL hop_accept_y got %0d exp 448", frog_y); end
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0);
      checks++;
      if (frog_y !== 10'(448 - 8 * k)) begin errors++; $display("FAIL hop_y%0d got %0d exp %0d", k, frog_y, 448 - 8 * k); end
    end
    tick(1'b0);
    checks++; if (frog_y !== 10'd416 || frog_x !== 10'd304) begin errors++; $display("FAIL hop_rest got %0d/%0d exp 304/416", frog_x, frog_y); end
  endtask

  task automatic test_bounds();
    do_hop(0, 1, 0, 0);
    checks++; if (frog_y !== 10'd448) begin errors++; $display("FAIL down_hop got %0d exp 448", frog_y); end
    press(0, 1, 0, 0);
    tick(1'b0); tick(1'b0);
    checks++; if (frog_y !== 10'd448) begin errors++; $display("FAIL bottom_drop got %0d exp 448", frog_y); end
    for (int i = 0; i < 9; i++) do_hop(0, 0, 1, 0);
    checks++; if (frog_x !== 10'd16) begin errors++; $display("FAIL left_hops got %0d exp 16", frog_x); end
    press(0, 0, 1, 0);
    tick(1'b0); tick(1'b0);
    checks++; if (frog_x !== 10'd16) begin errors++; $display("FAIL left_drop got %0d exp 16", frog_x); end
  endtask

  task automatic test_back_to_back();
    press(1, 0, 0, 1);
    tick(1'b0); tick(1'b0);
    press(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1'b0);
    checks++; if (frog_y !== 10'd416 || frog_x !== 10'd16) begin errors++; $display("FAIL prio_up got %0d/%0d exp 16/416", frog_x, frog_y); end
    tick(1'b0);
    checks++; if (frog_x !== 10'd16) begin errors++; $display("FAIL b2b_accept got %0d exp 16", frog_x); end
    for (int i = 0; i < 4; i++) tick(1'b0);
    checks++; if (frog_x !== 10'd48 || frog_y !== 10'd416) begin errors++; $display("FAIL b2b_right got %0d/%0d exp 48/416", frog_x, frog_y); end
  endtask

  task automatic test_goal();
    pulse_reset();
    for (int i = 0; i < 13; i++) do_hop(1, 0, 0, 0);
    checks++; if (frog_y !== 10'd32) begin errors++; $display("FAIL goal_approach got %0d exp 32", frog_y); end
    press(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1'b0);
    checks++; if (frog_y !== 10'd8 || goal_seen !== 1'b0) begin errors++; $display("FAIL goal_pre got %0d/%b exp 8/0", frog_y, goal_seen); end
    tick(1'b0);
    checks++; if (goal_seen !== 1'b1) begin errors++; $display("FAIL goal_pulse got %b exp 1", goal_seen); end
    checks++; if (frog_x !== 10'd304 || frog_y !== 10'd448) begin errors++; $display("FAIL goal_reload got %0d/%0d exp 304/448", frog_x, frog_y); end
    @(negedge clk);
    checks++; if (goal !== 1'b0) begin errors++; $display("FAIL goal_one_cycle got %b exp 0", goal); end
  endtask

  task automatic test_death();
    press(1, 0, 0, 0);
    tick(1'b0); tick(1'b0); tick(1'b0);
    tick(1'b1);
    checks++; if (frog_y !== 10'd432) begin errors++; $display("FAIL death_pos got %0d exp 432", frog_y); end
    colPos = 10'd304;
    rowPos = 10'd432;
    @(negedge clk); @(negedge clk);
    checks++; if (color !== 6'b111100 || pix_valid !== 1'b1) begin errors++; $display("FAIL flash_on got %b/%b exp 111100/1", color, pix_valid); end
    for (int i = 0; i < 4; i++) tick(1'b0);
    @(negedge clk);
    checks++; if (color !== 6'b000000 || pix_valid !== 1'b0) begin errors++; $display("FAIL flash_off got %b/%b exp 000000/0", color, pix_valid); end
    for (int i = 0; i < 25; i++) tick(1'b0);
    checks++; if (lives !== 3'd3 || frog_y !== 10'd432) begin errors++; $display("FAIL death_hold got %0d/%0d exp 3/432", lives, frog_y); end
    tick(1'b0);
    checks++; if (lives !== 3'd2 || frog_x !== 10'd304 || frog_y !== 10'd448) begin errors++; $display("FAIL respawn got %0d %0d/%0d exp 2 304/448", lives, frog_x, frog_y); end
  endtask

  task automatic test_gameover();
    tick(1'b1);
    for (int i = 0; i < 30; i++) tick(1'b0);
    checks++; if (lives !== 3'd1 || game_over !== 1'b0) begin errors++; $display("FAIL death2 got %0d/%b exp 1/0", lives, game_over); end
    tick(1'b1);
    for (int i = 0; i < 30; i++) tick(1'b0);
    checks++; if (lives !== 3'd0 || game_over !== 1'b1) begin errors++; $display("FAIL death3 got %0d/%b exp 0/1", lives, game_over); end
    do_hop(1, 0, 0, 0);
    checks++; if (frog_y !== 10'd448 || game_over !== 1'b1) begin errors++; $display("FAIL gameover_hold got %0d/%b exp 448/1", frog_y, game_over); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (lives !== 3'd3 || game_over !== 1'b0) begin errors++; $display("FAIL async_rst_go got %0d/%b exp 3/0", lives, game_over); end
    @(negedge clk);
    rst_n = 1'b1;
    press(1, 0, 0, 0);
    tick(1'b0); tick(1'b0); tick(1'b0);
    checks++; if (frog_y !== 10'd432) begin errors++; $display("FAIL midhop got %0d exp 432", frog_y); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (frog_y !== 10'd448 || frog_x !== 10'd304) begin errors++; $display("FAIL async_rst_hop got %0d/%0d exp 304/448", frog_x, frog_y); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_hop_up();
    test_bounds();
    test_back_to_back();
    test_goal();
    test_death();
    test_gameover();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
